rs_block_sequencer: RTL and testbench

Top-level sequencer for the RS(15,11) decoder datapath. Accepts one 15-symbol codeword over a valid/ready input handshake and writes it into the codeword buffer. It drives the syndrome unit's load/accumulate strobes, starts the key-equation solver and waits for it with a timeout. It then streams the buffered symbols out over a valid/ready output handshake while stepping the Chien/correction unit. The block sits between the symbol source and the syndrome → solver → corrector chain and owns all block-level sequencing.

---
 rtl/rs_block_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_rs_block_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_block_sequencer.sv
// rs_block_sequencer
// ------------------
// Block-level sequencer for the RS(15,11) decoder datapath. One codeword is
// in flight at a time: it is collected symbol by symbol into the codeword
// buffer (while the syndrome unit accumulates), the key-equation solver is
// kicked and waited for with a timeout, and the buffered symbols are then
// streamed out while the Chien/correction unit is stepped in lockstep.
//
// Ports
//   clk_i            single clock, all state changes on the rising edge
//   reset_i          synchronous, active-high reset
//   in_valid_i       source has a symbol
//   in_ready_o       sequencer accepts a symbol (IDLE / COLLECT)
//   wr_en_o          buffer write strobe (in_valid_i & in_ready_o)
//   wr_addr_o        buffer write address of the symbol being accepted
//   syn_load_o       syndrome load strobe, only for symbol 0
//   syn_en_o         syndrome update strobe (same as wr_en_o)
//   solve_start_o    one-cycle pulse to the solver on SOLVE entry
//   solve_done_i     solver finished, sampled only in SOLVE
//   solve_fail_i     solver reports uncorrectable, qualified by solve_done_i
//   rd_addr_o        buffer read address of the symbol being presented
//   out_valid_o      output symbol available (CORRECT)
//   out_ready_i      sink accepts the symbol
//   out_last_o       marks the final symbol of the codeword
//   chien_step_o     corrector advance (out_valid_o & out_ready_i)
//   blk_fail_o       current block uncorrectable or solver timed out
//   state_o          debug: 0 IDLE, 1 COLLECT, 2 SOLVE, 3 CORRECT

module rs_block_sequencer #(
    parameter int N             = 15,
    parameter int SOLVE_TIMEOUT = 32
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic       wr_en_o,
    output logic [3:0] wr_addr_o,
    output logic       syn_load_o,
    output logic       syn_en_o,
    output logic       solve_start_o,
    input  logic       solve_done_i,
    input  logic       solve_fail_i,
    output logic [3:0] rd_addr_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       out_last_o,
    output logic       chien_step_o,
    output logic       blk_fail_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SOLVE   = 2'd2,
        CORRECT = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX     = 4'(N - 1);
    localparam logic [3:0] PRE_LAST_IDX = 4'(N - 2);
    localparam logic [7:0] WAIT_LAST    = 8'(SOLVE_TIMEOUT - 1);

    state_t     state_q;
    logic [3:0] wrIdx_q;
    logic [3:0] rdIdx_q;
    logic [7:0] waitCnt_q;
    logic       inReady_q;
    logic       solveStart_q;
    logic       outValid_q;
    logic       outLast_q;
    logic       blkFail_q;

    logic       wrEn;
    logic       chienStep;

    // Handshake strobes are the only combinational outputs. The input side
    // only ever has inReady_q high in IDLE/COLLECT and the output side only
    // has outValid_q high in CORRECT, so no extra state qualification is
    // needed here.
    assign wrEn      = in_valid_i & inReady_q;
    assign chienStep = outValid_q & out_ready_i;

    assign wr_en_o       = wrEn;
    assign syn_en_o      = wrEn;
    assign syn_load_o    = wrEn & (state_q == IDLE);
    assign chien_step_o  = chienStep;
    assign in_ready_o    = inReady_q;
    assign wr_addr_o     = wrIdx_q;
    assign rd_addr_o     = rdIdx_q;
    assign out_valid_o   = outValid_q;
    assign out_last_o    = outLast_q;
    assign solve_start_o = solveStart_q;
    assign blk_fail_o    = blkFail_q;
    assign state_o       = state_q;

    // Block sequencing FSM. Every non-strobe output is a register updated
    // here alongside the state, so each transition also sets up the output
    // values for the state being entered. The index counters are returned
    // to 0 on the transition out of their phase, so they never count past
    // N-1. OUT_LAST is precomputed one transfer ahead so it is already high
    // while the final symbol is being presented.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            wrIdx_q      <= '0;
            rdIdx_q      <= '0;
            waitCnt_q    <= '0;
            inReady_q    <= 1'b1;
            solveStart_q <= 1'b0;
            outValid_q   <= 1'b0;
            outLast_q    <= 1'b0;
            blkFail_q    <= 1'b0;
        end else begin
            solveStart_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wrEn) begin
                        wrIdx_q <= 4'd1;
                        state_q <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (wrEn) begin
                        if (wrIdx_q == LAST_IDX) begin
                            wrIdx_q      <= '0;
                            inReady_q    <= 1'b0;
                            solveStart_q <= 1'b1;
                            waitCnt_q    <= '0;
                            state_q      <= SOLVE;
                        end else begin
                            wrIdx_q <= wrIdx_q + 4'd1;
                        end
                    end
                end

                SOLVE: begin
                    waitCnt_q <= waitCnt_q + 8'd1;
                    // A solver answer in the final allowed cycle still
                    // counts, so it is checked before the timeout.
                    if (solve_done_i) begin
                        blkFail_q  <= solve_fail_i;
                        rdIdx_q    <= '0;
                        outValid_q <= 1'b1;
                        outLast_q  <= (LAST_IDX == 4'd0);
                        state_q    <= CORRECT;
                    end else if (waitCnt_q == WAIT_LAST) begin
                        blkFail_q  <= 1'b1;
                        rdIdx_q    <= '0;
                        outValid_q <= 1'b1;
                        outLast_q  <= (LAST_IDX == 4'd0);
                        state_q    <= CORRECT;
                    end
                end

                CORRECT: begin
                    if (chienStep) begin
                        if (rdIdx_q == LAST_IDX) begin
                            rdIdx_q    <= '0;
                            outValid_q <= 1'b0;
                            outLast_q  <= 1'b0;
                            blkFail_q  <= 1'b0;
                            inReady_q  <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            rdIdx_q   <= rdIdx_q + 4'd1;
                            outLast_q <= (rdIdx_q == PRE_LAST_IDX);
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_block_sequencer.sv
// tb_rs_block_sequencer
// ---------------------
// Self-checking bench for rs_block_sequencer. Each scenario task pushes one
// or more codewords through the sequencer with randomized handshakes and
// compares the DUT every cycle against a transaction-level expectation:
// symbols counted so far on the input side, solver cycles elapsed, symbols
// delivered on the output side, and the fail verdict decided by how the
// solver phase ended.

module tb_rs_block_sequencer;

    localparam int N   = 15;
    localparam int TMO = 32;

    logic clk        = 1'b0;
    logic reset      = 1'b1;
    logic inValid    = 1'b0;
    logic solveDone  = 1'b0;
    logic solveFail  = 1'b0;
    logic outReady   = 1'b0;

    logic       inReadyO;
    logic       wrEnO;
    logic [3:0] wrAddrO;
    logic       synLoadO;
    logic       synEnO;
    logic       solveStartO;
    logic [3:0] rdAddrO;
    logic       outValidO;
    logic       outLastO;
    logic       chienStepO;
    logic       blkFailO;
    logic [1:0] stateO;

    int nChecks = 0;
    int nFails  = 0;

    rs_block_sequencer #(
        .N             (N),
        .SOLVE_TIMEOUT (TMO)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .in_valid_i    (inValid),
        .in_ready_o    (inReadyO),
        .wr_en_o       (wrEnO),
        .wr_addr_o     (wrAddrO),
        .syn_load_o    (synLoadO),
        .syn_en_o      (synEnO),
        .solve_start_o (solveStartO),
        .solve_done_i  (solveDone),
        .solve_fail_i  (solveFail),
        .rd_addr_o     (rdAddrO),
        .out_valid_o   (outValidO),
        .out_ready_i   (outReady),
        .out_last_o    (outLastO),
        .chien_step_o  (chienStepO),
        .blk_fail_o    (blkFailO),
        .state_o       (stateO)
    );

    // Free-running clock; inputs change #1 after the rising edge and
    // outputs are sampled on the falling edge.
    always #5 clk = ~clk;

    // Hard stop in case anything ever stalls beyond the per-phase budgets.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Pushes one codeword through all phases. doneDelay is the SOLVE cycle
    // (0-based) in which SOLVE_DONE is raised; a negative or too-large value
    // means the solver never answers. abortWr / abortRd raise reset while
    // the given input / output index is presented and return immediately
    // with reset high, leaving the post-reset checks to the caller.
    task automatic run_block(input int inPct, input int outPct,
                             input int doneDelay, input bit doneFail,
                             input bit noiseCollect,
                             input int abortWr, input int abortRd,
                             input string tag);
        int acc;
        int k;
        int o;
        int budget;
        bit expFail;
        bit exitNow;
        logic [1:0]  expState;
        logic [18:0] gotC, expC;
        logic [8:0]  gotS, expS;
        logic [12:0] gotO, expO;

        acc = 0;
        budget = 0;
        expFail = 1'b0;
        while (acc < N) begin
            inValid  = ($urandom_range(99) < inPct);
            outReady = 1'($urandom_range(1));
            if (noiseCollect) begin
                solveDone = 1'($urandom_range(1));
                solveFail = 1'($urandom_range(1));
            end else begin
                solveDone = 1'b0;
                solveFail = 1'b0;
            end
            @(negedge clk);
            expState = (acc == 0) ? 2'd0 : 2'd1;
            gotC = {stateO, inReadyO, wrAddrO, wrEnO, synEnO, synLoadO,
                    solveStartO, outValidO, chienStepO, outLastO, blkFailO, rdAddrO};
            expC = {expState, 1'b1, 4'(acc), inValid, inValid, inValid && (acc == 0),
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
            nChecks++;
            if (gotC !== expC) begin
                nFails++;
                $display("[TB] FAIL %s collect sym=%0d: got %h expected %h", tag, acc, gotC, expC);
            end
            if (abortWr == acc) begin
                reset = 1'b1;
                return;
            end
            if (inValid) acc++;
            @(posedge clk); #1;
            budget++;
            if (budget > 2000) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL %s collect budget: got %0d symbols expected %0d", tag, acc, N);
                return;
            end
        end

        k = 0;
        exitNow = 1'b0;
        while (!exitNow) begin
            inValid   = 1'($urandom_range(1));
            outReady  = 1'($urandom_range(1));
            solveDone = (k == doneDelay);
            solveFail = (k == doneDelay) ? doneFail : 1'($urandom_range(1));
            @(negedge clk);
            gotS = {stateO, inReadyO, wrEnO, synEnO, synLoadO, solveStartO, outValidO, chienStepO};
            expS = {2'd2, 1'b0, 1'b0, 1'b0, 1'b0, (k == 0), 1'b0, 1'b0};
            nChecks++;
            if (gotS !== expS) begin
                nFails++;
                $display("[TB] FAIL %s solve cycle=%0d: got %h expected %h", tag, k, gotS, expS);
            end
            if (solveDone) begin
                expFail = doneFail;
                exitNow = 1'b1;
            end else if (k == TMO - 1) begin
                expFail = 1'b1;
                exitNow = 1'b1;
            end
            @(posedge clk); #1;
            k++;
        end

        o = 0;
        budget = 0;
        while (o < N) begin
            outReady  = ($urandom_range(99) < outPct);
            inValid   = 1'($urandom_range(1));
            solveDone = 1'($urandom_range(1));
            solveFail = 1'($urandom_range(1));
            @(negedge clk);
            gotO = {stateO, inReadyO, outValidO, rdAddrO, outLastO, blkFailO,
                    chienStepO, wrEnO, solveStartO};
            expO = {2'd3, 1'b0, 1'b1, 4'(o), (o == N - 1), expFail,
                    outReady, 1'b0, 1'b0};
            nChecks++;
            if (gotO !== expO) begin
                nFails++;
                $display("[TB] FAIL %s correct sym=%0d: got %h expected %h", tag, o, gotO, expO);
            end
            if (abortRd == o) begin
                reset = 1'b1;
                return;
            end
            if (outReady) o++;
            @(posedge clk); #1;
            budget++;
            if (budget > 2000) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL %s correct budget: got %0d symbols expected %0d", tag, o, N);
                return;
            end
        end
        inValid   = 1'b0;
        solveDone = 1'b0;
        solveFail = 1'b0;
    endtask

    // Reset with every input active: outputs must show a quiet IDLE.
    task automatic test_reset();
        logic [18:0] got, exp;
        reset = 1'b1;
        inValid = 1'b1;
        outReady = 1'b1;
        solveDone = 1'b1;
        solveFail = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        inValid = 1'b0;
        @(negedge clk);
        got = {stateO, inReadyO, wrAddrO, rdAddrO, outValidO, outLastO,
               solveStartO, blkFailO, wrEnO, synEnO, synLoadO, chienStepO};
        exp = {2'd0, 1'b1, 4'd0, 4'd0, 8'd0};
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL reset state: got %h expected %h", got, exp);
        end
        @(posedge clk); #1;
        solveDone = 1'b0;
        solveFail = 1'b0;
    endtask

    // Continuous streaming, solver answers three cycles after the start.
    task automatic test_stream();
        run_block(100, 100, 3, 1'b0, 1'b0, -1, -1, "stream");
    endtask

    // Minimum-period blocks directly after one another.
    task automatic test_back_to_back();
        run_block(100, 100, 0, 1'b0, 1'b0, -1, -1, "b2b0");
        run_block(100, 100, 0, 1'b1, 1'b0, -1, -1, "b2b1");
        run_block(100, 100, 1, 1'b0, 1'b0, -1, -1, "b2b2");
    endtask

    // Solver never answers: full timeout, forced fail verdict.
    task automatic test_timeout();
        run_block(100, 100, -1, 1'b0, 1'b0, -1, -1, "timeout");
    endtask

    // Answer arriving in the very cycle the timeout expires.
    task automatic test_done_at_timeout();
        run_block(100, 100, TMO - 1, 1'b1, 1'b0, -1, -1, "edgefail");
        run_block(100, 100, TMO - 1, 1'b0, 1'b0, -1, -1, "edgepass");
    endtask

    // Random 50% handshakes with solver noise during collection.
    task automatic test_random();
        for (int b = 0; b < 5; b++) begin
            run_block(50, 50, int'($urandom_range(TMO + 8)), 1'($urandom_range(1)),
                      1'b1, -1, -1, "random");
        end
    endtask

    // Reset in the middle of collection and in the middle of output.
    task automatic test_reset_midblock();
        logic [18:0] got, exp;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0)
                run_block(100, 100, 2, 1'b0, 1'b0, 7, -1, "abortwr");
            else
                run_block(100, 100, 0, 1'b1, 1'b0, -1, 5, "abortrd");
            @(posedge clk); #1;
            reset = 1'b0;
            inValid = 1'b0;
            outReady = 1'b1;
            solveDone = 1'b1;
            solveFail = 1'b1;
            @(negedge clk);
            got = {stateO, inReadyO, wrAddrO, rdAddrO, outValidO, outLastO,
                   solveStartO, blkFailO, wrEnO, synEnO, synLoadO, chienStepO};
            exp = {2'd0, 1'b1, 4'd0, 4'd0, 8'd0};
            nChecks++;
            if (got !== exp) begin
                nFails++;
                $display("[TB] FAIL reset midblock pass=%0d: got %h expected %h", pass, got, exp);
            end
            @(posedge clk); #1;
            solveDone = 1'b0;
            solveFail = 1'b0;
            run_block(100, 100, 1, 1'b0, 1'b0, -1, -1, "restart");
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_timeout();
        test_done_at_timeout();
        test_random();
        test_reset_midblock();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
